// File: rtl/sec_timer_if.sv
// sec_timer_if: bundle of time-base pulses, user pulses and display/status outputs
//   master (time base / user side) drives:
//     tick_1s, scan_tick, start_stop, clear, load : one-clk pulses
//     load_val[15:0]                              : BCD {M1,M0,S1,S0}
//   slave (sec_timer_ctrl) drives:
//     digit_sel[3:0] : active-low one-hot digit enable, 4'hF = blank
//     digit_bcd[3:0] : BCD nibble of the selected digit
//     alarm, running : status levels
//     load_err       : one-clk pulse on a rejected load
interface sec_timer_if;
    logic        tick_1s;
    logic        scan_tick;
    logic        start_stop;
    logic        clear;
    logic        load;
    logic [15:0] load_val;
    logic [3:0]  digit_sel;
    logic [3:0]  digit_bcd;
    logic        alarm;
    logic        running;
    logic        load_err;
    modport master (
        output tick_1s, scan_tick, start_stop, clear, load, load_val,
        input  digit_sel, digit_bcd, alarm, running, load_err
    );
    modport slave (
        input  tick_1s, scan_tick, start_stop, clear, load, load_val,
        output digit_sel, digit_bcd, alarm, running, load_err
    );
endinterface

// File: rtl/sec_timer_ctrl.sv
// sec_timer_ctrl: MM:SS BCD countdown timer with IDLE/RUN/PAUSE/EXPIRE sequencing
//   and a multiplexed 4-digit seven-segment scan.
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   tmr   : sec_timer_if.slave (time-base/user pulses in, display and status out)
//   Optional BLINK_EN: blanks the display on alternate seconds in PAUSE/EXPIRE.
module sec_timer_ctrl #(
    parameter int unsigned ALARM_SECS   = 5,
    parameter logic [15:0] LOAD_DEFAULT = 16'h0100
) (
    input logic        clk,
    input logic        reset,
    sec_timer_if.slave tmr
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRE} state_t;
    localparam logic [3:0] ALARM_LAST = 4'(ALARM_SECS - 1);
    state_t      state_q, state_d;
    logic [15:0] count_q, count_d, count_dec;
    logic [3:0]  alarm_cnt_q, alarm_cnt_d;
    logic [1:0]  scan_idx_q;
    logic [3:0]  digit_sel_q, digit_bcd_q;
    logic        alarm_q, running_q, load_err_q, load_err_d;
    logic        load_ok, count_zero, b0, b1, b2;
    assign count_zero = count_q == 16'h0000;
    // b0..b2: every lower digit is zero, so this digit must take the borrow
    assign b0 = count_q[3:0] == 4'd0;
    assign b1 = b0 && count_q[7:4] == 4'd0;
    assign b2 = b1 && count_q[11:8] == 4'd0;
    assign count_dec = {
        b2 ? count_q[15:12] - 4'd1 : count_q[15:12],
        b1 ? (count_q[11:8] == 4'd0 ? 4'd9 : count_q[11:8] - 4'd1) : count_q[11:8],
        b0 ? (count_q[7:4] == 4'd0 ? 4'd5 : count_q[7:4] - 4'd1) : count_q[7:4],
        b0 ? 4'd9 : count_q[3:0] - 4'd1
    };
    assign load_ok = tmr.load_val[3:0] <= 4'd9 && tmr.load_val[7:4] <= 4'd5 &&
                     tmr.load_val[11:8] <= 4'd9 && tmr.load_val[15:12] <= 4'd9;
    // One input acts per cycle: clear > load > start_stop > tick_1s.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        alarm_cnt_d = alarm_cnt_q;
        load_err_d  = 1'b0;
        if (tmr.clear) begin
            state_d     = IDLE;
            count_d     = 16'h0000;
            alarm_cnt_d = 4'd0;
        end else if (tmr.load) begin
            if ((state_q == IDLE || state_q == PAUSE) && load_ok) count_d = tmr.load_val;
            else load_err_d = 1'b1;
        end else if (tmr.start_stop) begin
            case (state_q)
                IDLE:    state_d = count_zero ? IDLE : RUN;
                RUN:     state_d = PAUSE;
                PAUSE:   state_d = RUN;
                default: begin
                    state_d     = IDLE;
                    alarm_cnt_d = 4'd0;
                end
            endcase
        end else if (tmr.tick_1s) begin
            if (state_q == RUN && !count_zero) begin
                count_d = count_dec;
                state_d = count_dec == 16'h0000 ? EXPIRE : RUN;
            end else if (state_q == EXPIRE) begin
                state_d     = alarm_cnt_q == ALARM_LAST ? IDLE : EXPIRE;
                alarm_cnt_d = alarm_cnt_q == ALARM_LAST ? 4'd0 : alarm_cnt_q + 4'd1;
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            count_q     <= LOAD_DEFAULT;
            alarm_cnt_q <= 4'd0;
            scan_idx_q  <= 2'd0;
            digit_sel_q <= 4'hF;
            digit_bcd_q <= 4'd0;
            alarm_q     <= 1'b0;
            running_q   <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            alarm_cnt_q <= alarm_cnt_d;
            load_err_q  <= load_err_d;
            alarm_q     <= state_d == EXPIRE;
            running_q   <= state_d == RUN;
            // Each scan pulse shows the digit at the current index, then advances,
            // so the first pulse after reset lights S0.
            if (tmr.scan_tick) begin
                scan_idx_q  <= scan_idx_q + 2'd1;
                digit_sel_q <= ~(4'd1 << scan_idx_q);
                digit_bcd_q <= count_q[{scan_idx_q, 2'b00} +: 4];
            end
        end
    end
`ifdef BLINK_EN
    logic blink_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) blink_q <= 1'b0;
        else blink_q <= (state_q == PAUSE || state_q == EXPIRE) ? blink_q ^ tmr.tick_1s : 1'b0;
    end
    assign tmr.digit_sel = blink_q ? 4'hF : digit_sel_q;
`else
    assign tmr.digit_sel = digit_sel_q;
`endif
    assign tmr.digit_bcd = digit_bcd_q;
    assign tmr.alarm     = alarm_q;
    assign tmr.running   = running_q;
    assign tmr.load_err  = load_err_q;
endmodule

// File: tb/tb_sec_timer_ctrl.sv
// tb_sec_timer_ctrl: directed bench for sec_timer_ctrl with a seconds-based reference model
module tb_sec_timer_ctrl;
    localparam int ALARM_SECS = 5;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_EXPIRE = 3;
    logic clk, reset;
    int n_cmp, n_bad;
    sec_timer_if tif();
    sec_timer_ctrl #(.ALARM_SECS(ALARM_SECS), .LOAD_DEFAULT(16'h0100)) dut (
        .clk(clk),
        .reset(reset),
        .tmr(tif)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    // Reference model: countdown held as whole seconds, display order from the scan table.
    logic [3:0] sel_tab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    int ms, secs, acnt, pos;
    logic [3:0] m_sel, m_bcd;
    logic m_err;
    function automatic logic [15:0] to_bcd(input int t);
        int m, s;
        m = t / 60;
        s = t % 60;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction
    function automatic int from_bcd(input logic [15:0] v);
        return (int'(v[15:12]) * 10 + int'(v[11:8])) * 60 + int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction
    function automatic bit bcd_ok(input logic [15:0] v);
        return v[3:0] <= 4'd9 && v[7:4] <= 4'd5 && v[11:8] <= 4'd9 && v[15:12] <= 4'd9;
    endfunction
    task automatic model_reset();
        ms = M_IDLE; secs = from_bcd(16'h0100); acnt = 0; pos = 0;
        m_sel = 4'hF; m_bcd = 4'h0; m_err = 1'b0;
    endtask
    task automatic model_edge();
        logic [15:0] b;
        if (tif.scan_tick) begin
            b = to_bcd(secs);
            m_sel = sel_tab[pos];
            m_bcd = b[pos*4 +: 4];
            pos = (pos + 1) % 4;
        end
        m_err = 1'b0;
        if (tif.clear) begin
            ms = M_IDLE; secs = 0; acnt = 0;
        end else if (tif.load) begin
            if ((ms == M_IDLE || ms == M_PAUSE) && bcd_ok(tif.load_val)) secs = from_bcd(tif.load_val);
            else m_err = 1'b1;
        end else if (tif.start_stop) begin
            if (ms == M_IDLE) begin
                if (secs != 0) ms = M_RUN;
            end else if (ms == M_RUN) ms = M_PAUSE;
            else if (ms == M_PAUSE) ms = M_RUN;
            else begin
                ms = M_IDLE; acnt = 0;
            end
        end else if (tif.tick_1s) begin
            if (ms == M_RUN && secs > 0) begin
                secs = secs - 1;
                if (secs == 0) ms = M_EXPIRE;
            end else if (ms == M_EXPIRE) begin
                acnt = acnt + 1;
                if (acnt == ALARM_SECS) begin
                    ms = M_IDLE; acnt = 0;
                end
            end
        end
    endtask
    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask
    task automatic check_all();
        chk("digit_sel", {12'h0, tif.digit_sel}, {12'h0, m_sel});
        chk("digit_bcd", {12'h0, tif.digit_bcd}, {12'h0, m_bcd});
        chk("alarm", {15'h0, tif.alarm}, {15'h0, ms == M_EXPIRE});
        chk("running", {15'h0, tif.running}, {15'h0, ms == M_RUN});
        chk("load_err", {15'h0, tif.load_err}, {15'h0, m_err});
    endtask
    // One clock of stimulus: inputs held across one rising edge, then model step and compare.
    task automatic step(input logic c, l, s, t, sc, input logic [15:0] v);
        tif.clear = c; tif.load = l; tif.start_stop = s; tif.tick_1s = t;
        tif.scan_tick = sc; tif.load_val = v;
        @(posedge clk);
        model_edge();
        #2;
        check_all();
        tif.clear = 0; tif.load = 0; tif.start_stop = 0; tif.tick_1s = 0;
        tif.scan_tick = 0; tif.load_val = 16'h0;
    endtask
    task automatic idle();     step(0, 0, 0, 0, 0, 16'h0); endtask
    task automatic tick();     step(0, 0, 0, 1, 0, 16'h0); endtask
    task automatic ss();       step(0, 0, 1, 0, 0, 16'h0); endtask
    task automatic ld(input logic [15:0] v); step(0, 1, 0, 0, 0, v); endtask
    // Reassemble the displayed count from four scan positions.
    task automatic read_count(input string nm, input logic [15:0] exp);
        logic [15:0] val;
        val = 16'hxxxx;
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 0, 1, 16'h0);
            for (int j = 0; j < 4; j++)
                if (tif.digit_sel == sel_tab[j]) val[j*4 +: 4] = tif.digit_bcd;
        end
        chk(nm, val, exp);
    endtask
    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end
    initial begin
        n_cmp = 0; n_bad = 0;
        reset = 1'b0;
        tif.clear = 0; tif.load = 0; tif.start_stop = 0; tif.tick_1s = 0;
        tif.scan_tick = 0; tif.load_val = 16'h0;
        model_reset();
        @(posedge clk); @(posedge clk); #2;
        check_all();
        reset = 1'b1;
        // Reset display: blank until the first scan, then S0,S1,M0,M1 of 01:00.
        idle(); idle();
        chk("rst_blank", {12'h0, tif.digit_sel}, 16'h000F);
        begin
            logic [3:0] exp_sel [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
            logic [3:0] exp_bcd [4] = '{4'h0, 4'h0, 4'h1, 4'h0};
            for (int i = 0; i < 4; i++) begin
                step(0, 0, 0, 0, 1, 16'h0);
                chk("scan_sel", {12'h0, tif.digit_sel}, {12'h0, exp_sel[i]});
                chk("scan_bcd", {12'h0, tif.digit_bcd}, {12'h0, exp_bcd[i]});
            end
        end
        // 00:03 countdown to EXPIRE, then ALARM_SECS seconds of alarm.
        ld(16'h0003); ss();
        chk("run_after_start", {15'h0, tif.running}, 16'h0001);
        tick(); read_count("cnt_0002", 16'h0002);
        tick(); read_count("cnt_0001", 16'h0001);
        tick();
        chk("alarm_on", {15'h0, tif.alarm}, 16'h0001);
        chk("run_off_expire", {15'h0, tif.running}, 16'h0000);
        read_count("cnt_0000", 16'h0000);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("alarm_hold", {15'h0, tif.alarm}, 16'h0001);
        end
        tick();
        chk("alarm_done", {15'h0, tif.alarm}, 16'h0000);
        // Minute borrow.
        ld(16'h0100); ss(); tick();
        read_count("cnt_0059", 16'h0059);
        // start_stop beats tick: pause and resume without decrement.
        step(0, 0, 1, 1, 0, 16'h0);
        chk("pause_run", {15'h0, tif.running}, 16'h0000);
        read_count("pause_0059", 16'h0059);
        tick(); read_count("pause_tick_0059", 16'h0059);
        step(0, 0, 1, 1, 0, 16'h0);
        chk("resume_run", {15'h0, tif.running}, 16'h0001);
        read_count("resume_0059", 16'h0059);
        tick(); read_count("cnt_0058", 16'h0058);
        // Load rejected in RUN, bad BCD rejected in PAUSE, good loads accepted.
        ld(16'h0030);
        chk("err_run", {15'h0, tif.load_err}, 16'h0001);
        idle();
        chk("err_pulse", {15'h0, tif.load_err}, 16'h0000);
        read_count("run_keep_0058", 16'h0058);
        ss(); ld(16'h0070);
        chk("err_bcd", {15'h0, tif.load_err}, 16'h0001);
        read_count("bad_keep_0058", 16'h0058);
        ld(16'h1234);
        chk("load_ok", {15'h0, tif.load_err}, 16'h0000);
        read_count("cnt_1234", 16'h1234);
        // clear wins over load and start_stop.
        ss();
        step(1, 1, 1, 0, 0, 16'h0500);
        chk("clear_run", {15'h0, tif.running}, 16'h0000);
        read_count("clear_0000", 16'h0000);
        ss();
        chk("start_zero", {15'h0, tif.running}, 16'h0000);
        // Early acknowledge of the alarm.
        ld(16'h0001); ss(); tick();
        chk("alarm_ack_pre", {15'h0, tif.alarm}, 16'h0001);
        ss();
        chk("alarm_ack", {15'h0, tif.alarm}, 16'h0000);
        chk("ack_idle", {15'h0, tif.running}, 16'h0000);
        // Ten-minute borrow through all digits.
        ld(16'h1000); ss(); tick();
        read_count("cnt_0959", 16'h0959);
        chk("model_0959", to_bcd(secs), 16'h0959);
        // Asynchronous reset while running.
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        chk("async_run", {15'h0, tif.running}, 16'h0000);
        chk("async_blank", {12'h0, tif.digit_sel}, 16'h000F);
        @(posedge clk); #2;
        check_all();
        reset = 1'b1;
        idle();
        read_count("rst_0100", 16'h0100);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
